instr_loader: RTL

Boot-time program loader that sits directly upstream of the instruction memory in the single-cycle RV32I core. It accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them sequentially into instruction memory. It holds the core in reset until a complete frame with a correct checksum has been written.

---
 rtl/instr_loader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
// instr_loader: boot-time program loader in front of the RV32I instruction memory.
// Accepts a framed byte stream {LEN_LO, LEN_HI, 4*N payload bytes, CHK}, assembles
// little-endian 32-bit words and writes them to sequential word addresses. The core
// is held in reset until a full frame with a matching 8-bit checksum has been written.
//
// Latency: mem_we pulses one cycle after the 4th byte of a word is accepted; done/err
// rise one cycle after the deciding byte (LEN_HI or CHK).
// Backpressure: in_ready is high in every non-terminal state (never stalls mid-frame)
// and low in S_DONE/S_ERR and while areset is asserted.
//
// Ports:
//   clk, areset            clock, synchronous active-high reset
//   in_valid/in_data       byte stream input, in_ready accepts
//   mem_we/mem_addr/mem_wdata  instruction memory write port (byte address, word aligned)
//   core_rst               core reset, released only after a verified load
//   done / err             sticky load result flags
//   words_loaded           number of words written since reset

module instr_loader #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  // One extra bit so MEM_WORDS = 65536 still compares correctly against a 16-bit count.
  localparam logic [16:0] MAX_WORDS = 17'(MEM_WORDS);

  state_t      state_q,     state_d;
  logic [15:0] len_q,       len_d;
  logic [1:0]  byte_idx_q,  byte_idx_d;
  logic [15:0] word_idx_q,  word_idx_d;
  logic [7:0]  sum_q,       sum_d;
  // Only the lower three lanes are stored; the 4th byte goes straight into mem_wdata.
  logic [23:0] asm_q,       asm_d;
  logic        mem_we_q,    mem_we_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [15:0] words_q,     words_d;

  logic        xfer;
  logic [15:0] len_full;
  logic        last_word;

  // Terminal states refuse bytes; reset forces in_ready low combinationally.
  assign in_ready  = !areset && (state_q != S_DONE) && (state_q != S_ERR);
  assign xfer      = in_valid && in_ready;
  assign len_full  = {in_data, len_q[7:0]};
  // len_q is nonzero whenever S_DATA is active, so len_q-1 never wraps here.
  assign last_word = (word_idx_q == (len_q - 16'd1));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    byte_idx_d  = byte_idx_q;
    word_idx_d  = word_idx_q;
    sum_d       = sum_q;
    asm_d       = asm_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    words_d     = words_q;

    case (state_q)
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = in_data;
          state_d    = S_LEN_HI;
        end
      end

      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = in_data;
          if ({1'b0, len_full} > MAX_WORDS) begin
            state_d = S_ERR;
          end else if (len_full == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (xfer) begin
          sum_d      = sum_q + in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: asm_d[7:0]   = in_data;
            2'd1: asm_d[15:8]  = in_data;
            2'd2: asm_d[23:16] = in_data;
            default: begin
              mem_we_d    = 1'b1;
              mem_wdata_d = {in_data, asm_q};
              mem_addr_d  = {14'd0, word_idx_q, 2'b00};
              word_idx_d  = word_idx_q + 16'd1;
              words_d     = words_q + 16'd1;
              if (last_word) begin
                state_d = S_CHECK;
              end
            end
          endcase
        end
      end

      S_CHECK: begin
        if (xfer) begin
          state_d = (in_data == sum_q) ? S_DONE : S_ERR;
        end
      end

      default: begin
        // S_DONE / S_ERR hold until reset.
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q     <= S_LEN_LO;
      len_q       <= 16'd0;
      byte_idx_q  <= 2'd0;
      word_idx_q  <= 16'd0;
      sum_q       <= 8'd0;
      asm_q       <= 24'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      words_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      byte_idx_q  <= byte_idx_d;
      word_idx_q  <= word_idx_d;
      sum_q       <= sum_d;
      asm_q       <= asm_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      words_q     <= words_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign words_loaded = words_q;
  assign done         = (state_q == S_DONE);
  assign err          = (state_q == S_ERR);
  assign core_rst     = (state_q != S_DONE);

endmodule
